// File: rtl/pipelined_cpu.sv
// Five-stage (IF/ID/EX/MEM/WB) MIPS-subset core: EX forwarding, one-cycle
// load-use stall, and branch/jump resolution in ID with a single flushed slot.
module pipelined_cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        start_i,
  output logic [31:0] pc_o,
  output logic        stall_o,
  output logic        flush_o
);
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] wdata;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dst;
    logic [31:0] result;
  } mem_wb_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [31:0] imem [IMEM_WORDS];
  logic [7:0]  dmem [DMEM_BYTES];
  logic [31:0] rf   [32];

  logic [31:0] pc, pc_next;
  if_id_t  if_id,  if_id_next;
  id_ex_t  id_ex,  id_ex_next;
  ex_mem_t ex_mem, ex_mem_next;
  mem_wb_t mem_wb, mem_wb_next;

  // ---------------- ID: decode, register read, hazard and branch ----------------
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, rs_val, rt_val;
  logic        stall, taken;
  ctrl_t       ctrl;
  logic [4:0]  dst;

  assign op       = if_id.instr[31:26];
  assign funct    = if_id.instr[5:0];
  assign rs       = if_id.instr[25:21];
  assign rt       = if_id.instr[20:16];
  assign rd       = if_id.instr[15:11];
  assign imm_sext = {{16{if_id.instr[15]}}, if_id.instr[15:0]};

  // Write-through: a register retiring this cycle is visible to ID immediately.
  assign rs_val = (mem_wb.reg_write && mem_wb.dst != 5'd0 && mem_wb.dst == rs) ? mem_wb.result : rf[rs];
  assign rt_val = (mem_wb.reg_write && mem_wb.dst != 5'd0 && mem_wb.dst == rt) ? mem_wb.result : rf[rt];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    ctrl = '0;
    dst  = rd;
    unique case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        unique case (funct)
          6'b100000: ctrl.alu_op = ALU_ADD;
          6'b100010: ctrl.alu_op = ALU_SUB;
          6'b100100: ctrl.alu_op = ALU_AND;
          6'b100101: ctrl.alu_op = ALU_OR;
          6'b011000: ctrl.alu_op = ALU_MUL;
          default:   ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        dst            = rt;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        dst             = rt;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall = id_ex.ctrl.mem_read && (id_ex.dst == rs || id_ex.dst == rt);
  assign taken = (op == OP_BEQ && rs_val == rt_val) || op == OP_J;

  // ---------------- IF and next-state of the front end ----------------
  always_comb begin
    pc_next    = pc + 32'd4;
    if_id_next = '{pc4: pc + 32'd4, instr: imem[pc[9:2]]};
    id_ex_next = '{ctrl: ctrl, rs: rs, rt: rt, dst: dst, a: rs_val, b: rt_val, imm: imm_sext};
    if (stall) begin
      // A stalled load-use pair outranks a branch; the branch re-resolves next cycle.
      pc_next    = pc;
      if_id_next = if_id;
      id_ex_next = '0;
    end else if (taken) begin
      pc_next    = (op == OP_J) ? {if_id.pc4[31:28], if_id.instr[25:0], 2'b00}
                                : if_id.pc4 + {imm_sext[29:0], 2'b00};
      if_id_next = '0;
    end
  end

  // ---------------- EX: forwarding and ALU ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y;

  always_comb begin
    fwd_a = id_ex.a;
    if (ex_mem.reg_write && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rs) fwd_a = ex_mem.alu;
    else if (mem_wb.reg_write && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rs) fwd_a = mem_wb.result;
    fwd_b = id_ex.b;
    if (ex_mem.reg_write && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rt) fwd_b = ex_mem.alu;
    else if (mem_wb.reg_write && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rt) fwd_b = mem_wb.result;
  end

  assign alu_b = id_ex.ctrl.alu_src ? id_ex.imm : fwd_b;

  always_comb begin
    alu_y = fwd_a + alu_b;
    unique case (id_ex.ctrl.alu_op)
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_MUL: alu_y = fwd_a * alu_b;
      default: ;
    endcase
  end

  assign ex_mem_next = '{reg_write: id_ex.ctrl.reg_write, mem_write: id_ex.ctrl.mem_write,
                         mem_to_reg: id_ex.ctrl.mem_to_reg, dst: id_ex.dst,
                         alu: alu_y, wdata: fwd_b};

  // ---------------- MEM: word-aligned little-endian data memory ----------------
  logic [4:0]  ma0, ma1, ma2, ma3;
  logic [31:0] mdata;

  assign ma0   = {ex_mem.alu[4:2], 2'b00};
  assign ma1   = {ex_mem.alu[4:2], 2'b01};
  assign ma2   = {ex_mem.alu[4:2], 2'b10};
  assign ma3   = {ex_mem.alu[4:2], 2'b11};
  assign mdata = {dmem[ma3], dmem[ma2], dmem[ma1], dmem[ma0]};

  assign mem_wb_next = '{reg_write: ex_mem.reg_write, dst: ex_mem.dst,
                         result: ex_mem.mem_to_reg ? mdata : ex_mem.alu};

  // NOTE: the data memory has no reset branch; its contents survive start_i low.
  always_ff @(posedge clk_i) begin
    if (ex_mem.mem_write) begin
      dmem[ma0] <= ex_mem.wdata[7:0];
      dmem[ma1] <= ex_mem.wdata[15:8];
      dmem[ma2] <= ex_mem.wdata[23:16];
      dmem[ma3] <= ex_mem.wdata[31:24];
    end
  end

  // ---------------- State registers and WB ----------------
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of the stage behind it.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc     <= pc_next;
      if_id  <= if_id_next;
      id_ex  <= id_ex_next;
      ex_mem <= ex_mem_next;
      mem_wb <= mem_wb_next;
      if (mem_wb.reg_write && mem_wb.dst != 5'd0) rf[mem_wb.dst] <= mem_wb.result;
    end
  end

  assign pc_o    = pc;
  assign stall_o = stall;
  assign flush_o = taken && !stall;

endmodule

// File: tb/tb_pipelined_cpu.sv
// Self-checking bench for pipelined_cpu: directed scenarios plus random
// straight-line programs checked against an instruction-level ISA model.
module tb_pipelined_cpu;
  logic        clk_i = 1'b0;
  logic        start_i;
  logic [31:0] pc_o;
  logic        stall_o;
  logic        flush_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int stall_cnt, flush_cnt, both_cnt;

  logic [31:0] pc_tr [256];
  logic [31:0] prog  [256];
  logic [31:0] m_rf  [32];
  logic [31:0] m_mem [8];

  pipelined_cpu dut (
    .clk_i  (clk_i),
    .start_i(start_i),
    .pc_o   (pc_o),
    .stall_o(stall_o),
    .flush_o(flush_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Instruction encoders
  function automatic logic [31:0] r_ins(int rs, int rt, int rd, int funct);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction
  function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_ins(int word);
    return {6'b000010, 26'(word)};
  endfunction

  localparam int ADDI = 8, LW = 35, SW = 43, BEQ = 4;
  localparam int F_ADD = 32, F_SUB = 34, F_AND = 36, F_OR = 37, F_MUL = 24;

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
  endtask

  // Hold reset, load instruction memory, release on a falling edge.
  task automatic boot();
    start_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
    @(negedge clk_i);
    start_i = 1'b1;
  endtask

  task automatic run(int n);
    stall_cnt = 0;
    flush_cnt = 0;
    both_cnt  = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 256) pc_tr[i] = pc_o;
      if (stall_o) stall_cnt++;
      if (flush_o) flush_cnt++;
      if (stall_o && flush_o) both_cnt++;
      @(negedge clk_i);
    end
  endtask

  // Architectural (one instruction at a time) reference interpreter.
  task automatic model_run(int len);
    int          pc_w, steps;
    logic [31:0] ins, a, b, addr, res;
    logic [4:0]  dst;
    logic        wr;
    pc_w  = 0;
    steps = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    while (pc_w >= 0 && pc_w < len && steps < 2000) begin
      ins  = prog[pc_w];
      a    = m_rf[ins[25:21]];
      b    = m_rf[ins[20:16]];
      addr = a + {{16{ins[15]}}, ins[15:0]};
      wr   = 1'b0;
      dst  = ins[15:11];
      res  = 32'd0;
      pc_w = pc_w + 1;
      case (ins[31:26])
        6'd0: begin
          wr = 1'b1;
          case (ins[5:0])
            6'd32:   res = a + b;
            6'd34:   res = a - b;
            6'd36:   res = a & b;
            6'd37:   res = a | b;
            6'd24:   res = a * b;
            default: wr = 1'b0;
          endcase
        end
        6'd8:  begin wr = 1'b1; dst = ins[20:16]; res = addr; end
        6'd35: begin wr = 1'b1; dst = ins[20:16]; res = m_mem[addr[4:2]]; end
        6'd43: m_mem[addr[4:2]] = b;
        6'd4:  if (a == b) pc_w = pc_w + int'($signed(ins[15:0]));
        6'd2:  pc_w = int'(ins[25:0]);
        default: ;
      endcase
      if (wr && dst != 5'd0) m_rf[dst] = res;
      steps++;
    end
  endtask

  task automatic test_reset();
    clear_prog();
    start_i = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
    @(negedge clk_i);
    tests_run++;
    if (pc_o !== 32'd0 || stall_o !== 1'b0 || flush_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: pc=%h stall=%b flush=%b, required pc=0 stall=0 flush=0", pc_o, stall_o, flush_o);
    end
    start_i = 1'b1;
    run(10);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (pc_tr[i] !== 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL idle_pc[%0d]: got %h, required %h", i, pc_tr[i], 32'(4 * i));
      end
    end
    tests_run++;
    if (stall_cnt != 0 || flush_cnt != 0) begin
      tests_failed++;
      $display("FAIL idle_ctrl: stalls=%0d flushes=%0d, required 0/0", stall_cnt, flush_cnt);
    end
    for (int i = 0; i < 32; i++) begin
      tests_run++;
      if (dut.rf[i] !== 32'd0) begin
        tests_failed++;
        $display("FAIL idle_rf[%0d]: got %h, required 0", i, dut.rf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [5];
    clear_prog();
    prog[0] = i_ins(ADDI, 0, 1, 5);
    prog[1] = i_ins(ADDI, 1, 2, 3);
    prog[2] = r_ins(1, 2, 3, F_ADD);
    prog[3] = r_ins(3, 1, 4, F_SUB);
    exp = '{32'd0, 32'd5, 32'd8, 32'd13, 32'd8};
    boot();
    run(12);
    for (int i = 1; i < 5; i++) begin
      tests_run++;
      if (dut.rf[i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL fwd_r%0d: got %0d, required %0d", i, dut.rf[i], exp[i]);
      end
    end
    tests_run++;
    if (stall_cnt != 0) begin
      tests_failed++;
      $display("FAIL fwd_stalls: got %0d, required 0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    clear_prog();
    prog[0] = i_ins(ADDI, 0, 1, 5);
    prog[1] = i_ins(SW, 0, 1, 0);
    prog[2] = i_ins(LW, 0, 8, 0);
    prog[3] = r_ins(8, 8, 9, F_ADD);
    prog[4] = i_ins(SW, 0, 9, 4);
    boot();
    run(14);
    tests_run++;
    if (stall_cnt != 1) begin
      tests_failed++;
      $display("FAIL lu_stall_count: got %0d, required 1", stall_cnt);
    end
    tests_run++;
    if (dut.rf[9] !== 32'd10) begin
      tests_failed++;
      $display("FAIL lu_r9: got %0d, required 10", dut.rf[9]);
    end
    tests_run++;
    if ({dut.dmem[7], dut.dmem[6], dut.dmem[5], dut.dmem[4]} !== 32'd10 || dut.dmem[4] !== 8'd10) begin
      tests_failed++;
      $display("FAIL lu_mem4: got %h%h%h%h, required 0000000a (LSB at byte 4)",
               dut.dmem[7], dut.dmem[6], dut.dmem[5], dut.dmem[4]);
    end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      clear_prog();
      prog[0] = i_ins(ADDI, 0, 1, 5);
      prog[1] = i_ins(ADDI, 0, 2, (t == 0) ? 5 : 7);
      prog[4] = i_ins(BEQ, 1, 2, 1);
      prog[5] = i_ins(ADDI, 0, 3, 99);
      prog[6] = i_ins(ADDI, 0, 4, 1);
      boot();
      run(16);
      tests_run++;
      if (flush_cnt != ((t == 0) ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL beq%0d_flushes: got %0d, required %0d", t, flush_cnt, (t == 0) ? 1 : 0);
      end
      tests_run++;
      if (dut.rf[3] !== ((t == 0) ? 32'd0 : 32'd99) || dut.rf[4] !== 32'd1) begin
        tests_failed++;
        $display("FAIL beq%0d_regs: r3=%0d r4=%0d, required r3=%0d r4=1", t, dut.rf[3], dut.rf[4], (t == 0) ? 0 : 99);
      end
    end
  endtask

  task automatic test_stall_vs_branch();
    clear_prog();
    prog[0] = i_ins(ADDI, 0, 1, 5);
    prog[1] = i_ins(ADDI, 0, 2, 5);
    prog[2] = i_ins(SW, 0, 1, 0);
    prog[5] = i_ins(LW, 0, 1, 0);
    prog[6] = i_ins(BEQ, 1, 2, 1);
    prog[7] = i_ins(ADDI, 0, 3, 99);
    prog[8] = i_ins(ADDI, 0, 4, 1);
    boot();
    run(18);
    tests_run++;
    if (stall_cnt != 1 || flush_cnt != 1 || both_cnt != 0) begin
      tests_failed++;
      $display("FAIL stall_branch_ctrl: stalls=%0d flushes=%0d overlap=%0d, required 1/1/0", stall_cnt, flush_cnt, both_cnt);
    end
    tests_run++;
    if (dut.rf[3] !== 32'd0 || dut.rf[4] !== 32'd1) begin
      tests_failed++;
      $display("FAIL stall_branch_regs: r3=%0d r4=%0d, required r3=0 r4=1", dut.rf[3], dut.rf[4]);
    end
  endtask

  task automatic test_jump_mul();
    clear_prog();
    prog[0]  = i_ins(ADDI, 0, 1, 5);
    prog[1]  = i_ins(ADDI, 0, 2, 7);
    prog[2]  = j_ins(10);
    prog[3]  = i_ins(ADDI, 0, 3, 99);
    prog[10] = r_ins(1, 2, 5, F_MUL);
    boot();
    run(20);
    tests_run++;
    if (pc_tr[3] !== 32'd12 || pc_tr[4] !== 32'd40 || pc_tr[5] !== 32'd44) begin
      tests_failed++;
      $display("FAIL j_pc: got %0d,%0d,%0d, required 12,40,44", pc_tr[3], pc_tr[4], pc_tr[5]);
    end
    tests_run++;
    if (flush_cnt != 1 || dut.rf[3] !== 32'd0) begin
      tests_failed++;
      $display("FAIL j_slot: flushes=%0d r3=%0d, required 1 and 0", flush_cnt, dut.rf[3]);
    end
    tests_run++;
    if (dut.rf[5] !== 32'd35) begin
      tests_failed++;
      $display("FAIL mul_r5: got %0d, required 35", dut.rf[5]);
    end
  endtask

  task automatic test_async_reset();
    clear_prog();
    prog[0] = i_ins(ADDI, 0, 1, 85);
    prog[1] = i_ins(SW, 0, 1, 8);
    for (int i = 2; i < 12; i++) prog[i] = i_ins(ADDI, 0, i, i);
    boot();
    run(6);
    @(posedge clk_i);
    #2;
    tests_run++;
    if (dut.rf[1] !== 32'd85) begin
      tests_failed++;
      $display("FAIL arst_pre_r1: got %0d, required 85", dut.rf[1]);
    end
    start_i = 1'b0;
    #1;
    tests_run++;
    if (pc_o !== 32'd0 || stall_o !== 1'b0 || flush_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_outputs: pc=%h stall=%b flush=%b, required 0/0/0", pc_o, stall_o, flush_o);
    end
    tests_run++;
    if (dut.if_id !== '0 || dut.id_ex !== '0 || dut.ex_mem !== '0 || dut.mem_wb !== '0) begin
      tests_failed++;
      $display("FAIL arst_pipe: pipeline registers not cleared, required all zero");
    end
    tests_run++;
    if (dut.rf[1] !== 32'd0) begin
      tests_failed++;
      $display("FAIL arst_rf: r1=%0d, required 0", dut.rf[1]);
    end
    tests_run++;
    if ({dut.dmem[11], dut.dmem[10], dut.dmem[9], dut.dmem[8]} !== 32'd85) begin
      tests_failed++;
      $display("FAIL arst_mem: got %h%h%h%h, required 00000055", dut.dmem[11], dut.dmem[10], dut.dmem[9], dut.dmem[8]);
    end
    @(posedge clk_i);
    #1;
    tests_run++;
    if (pc_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL arst_hold_pc: got %h, required 0", pc_o);
    end
    @(negedge clk_i);
    start_i = 1'b1;
    run(20);
    tests_run++;
    if (dut.rf[1] !== 32'd85 || dut.rf[11] !== 32'd11) begin
      tests_failed++;
      $display("FAIL arst_rerun: r1=%0d r11=%0d, required 85 and 11", dut.rf[1], dut.rf[11]);
    end
  endtask

  task automatic test_random();
    int len, sel, rs, rt, rd;
    int functs [5];
    logic [31:0] got;
    functs = '{F_ADD, F_SUB, F_AND, F_OR, F_MUL};
    for (int iter = 0; iter < 6; iter++) begin
      clear_prog();
      len = 0;
      for (int k = 1; k < 8; k++) prog[len++] = i_ins(ADDI, 0, k, int'($urandom_range(0, 65535)));
      for (int w = 0; w < 8; w++) prog[len++] = i_ins(SW, 0, (w % 7) + 1, 4 * w);
      for (int k = 0; k < 40; k++) begin
        sel = int'($urandom_range(0, 10));
        rs  = int'($urandom_range(0, 7));
        rt  = int'($urandom_range(0, 7));
        rd  = int'($urandom_range(0, 7));
        case (sel)
          0, 1, 2, 3, 4: prog[len++] = r_ins(rs, rt, rd, functs[sel]);
          5:       prog[len++] = i_ins(ADDI, rs, rt, int'($urandom_range(0, 65535)));
          6, 7:    prog[len++] = i_ins(LW, rs, rt, int'($urandom_range(0, 65535)));
          8:       prog[len++] = i_ins(SW, rs, rt, int'($urandom_range(0, 65535)));
          9:       prog[len++] = i_ins(51, rs, rt, int'($urandom_range(0, 65535)));
          default: prog[len++] = r_ins(rs, rt, rd, 1);
        endcase
      end
      for (int w = 0; w < 8; w++) m_mem[w] = 32'd0;
      model_run(len);
      boot();
      run(2 * len + 12);
      for (int i = 0; i < 32; i++) begin
        tests_run++;
        if (dut.rf[i] !== m_rf[i]) begin
          tests_failed++;
          $display("FAIL rand%0d_r%0d: got %h, required %h", iter, i, dut.rf[i], m_rf[i]);
        end
      end
      for (int w = 0; w < 8; w++) begin
        got = {dut.dmem[4*w+3], dut.dmem[4*w+2], dut.dmem[4*w+1], dut.dmem[4*w]};
        tests_run++;
        if (got !== m_mem[w]) begin
          tests_failed++;
          $display("FAIL rand%0d_mem%0d: got %h, required %h", iter, w, got, m_mem[w]);
        end
      end
    end
  endtask

  initial begin
    start_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_stall_vs_branch();
    test_jump_mul();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
